// File: rtl/uart_tx_dev.sv
// Memory-mapped 8N1 UART transmitter: software pushes bytes into a small FIFO
// which a four-state serialiser drains onto txd at a programmable bit period.
module uart_tx_dev #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [15:0] DIV_RESET  = 16'd16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [29:0] Addr,
  input  logic        WE,
  input  logic [31:0] Din,
  output logic [31:0] Dout,
  output logic        txd,
  output logic        IRQ
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  localparam logic [1:0] A_DATA = 2'd0;
  localparam logic [1:0] A_CTRL = 2'd1;
  localparam logic [1:0] A_STAT = 2'd2;
  localparam logic [1:0] A_DIV  = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [7:0]    shift_q, shift_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [15:0]   cnt_q, cnt_d;
  logic [15:0]   period_q, period_d;
  logic          txd_q, txd_d;
  logic          txen_q, txen_d;
  logic          irqen_q, irqen_d;
  logic          ovr_q, ovr_d;
  logic [15:0]   div_q, div_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [7:0]    mem_q [FIFO_DEPTH];

  logic wr_data, wr_ctrl, wr_stat, wr_div;
  logic fifo_empty, fifo_full, bit_done, can_start;
  logic push_ok, pop;
  logic unused_bits;

  assign unused_bits = ^{Addr[29:2], Din[31:16]};

  assign wr_data = WE && (Addr[1:0] == A_DATA);
  assign wr_ctrl = WE && (Addr[1:0] == A_CTRL);
  assign wr_stat = WE && (Addr[1:0] == A_STAT);
  assign wr_div  = WE && (Addr[1:0] == A_DIV);

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CW'(FIFO_DEPTH));
  assign bit_done   = (cnt_q == period_q - 16'd1);
  assign can_start  = txen_q && !fifo_empty;

  // Serialiser. txd is registered, so each branch sets the level for the
  // state being entered rather than the one being left.
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    state_d   = state_q;
    shift_d   = shift_q;
    bit_idx_d = bit_idx_q;
    cnt_d     = cnt_q;
    period_d  = period_q;
    txd_d     = txd_q;
    pop       = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (can_start) begin
          pop      = 1'b1;
          state_d  = S_START;
          shift_d  = mem_q[rd_ptr_q];
          period_d = div_q;
          cnt_d    = '0;
          txd_d    = 1'b0;
        end
      end
      S_START: begin
        if (bit_done) begin
          state_d   = S_DATA;
          cnt_d     = '0;
          bit_idx_d = '0;
          txd_d     = shift_q[0];
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_DATA: begin
        if (bit_done) begin
          cnt_d = '0;
          if (bit_idx_q == 3'd7) begin
            state_d = S_STOP;
            txd_d   = 1'b1;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            shift_d   = {1'b0, shift_q[7:1]};
            txd_d     = shift_q[1];
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: begin
        if (bit_done) begin
          cnt_d = '0;
          if (can_start) begin
            pop      = 1'b1;
            state_d  = S_START;
            shift_d  = mem_q[rd_ptr_q];
            period_d = div_q;
            txd_d    = 1'b0;
          end else begin
            state_d = S_IDLE;
            txd_d   = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
    endcase
  end

  // A push into a full FIFO still fits when the head leaves in the same cycle.
  always_comb begin
    push_ok  = wr_data && (!fifo_full || pop);
    wr_ptr_d = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;

    unique case ({push_ok, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    ovr_d = ovr_q;
    if (wr_stat)
      ovr_d = 1'b0;
    else if (wr_data && !push_ok)
      ovr_d = 1'b1;

    txen_d  = wr_ctrl ? Din[0] : txen_q;
    irqen_d = wr_ctrl ? Din[1] : irqen_q;
    div_d   = div_q;
    if (wr_div)
      div_d = (Din[15:0] == 16'd0) ? 16'd1 : Din[15:0];
  end

  always_ff @(posedge clk) begin
    // NOTE: state uses non-blocking assignments so every flop samples the
    // values from before this edge, independent of statement order.
    if (reset) begin
      state_q   <= S_IDLE;
      shift_q   <= '0;
      bit_idx_q <= '0;
      cnt_q     <= '0;
      period_q  <= DIV_RESET;
      txd_q     <= 1'b1;
      txen_q    <= 1'b0;
      irqen_q   <= 1'b0;
      ovr_q     <= 1'b0;
      div_q     <= DIV_RESET;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_idx_q <= bit_idx_d;
      cnt_q     <= cnt_d;
      period_q  <= period_d;
      txd_q     <= txd_d;
      txen_q    <= txen_d;
      irqen_q   <= irqen_d;
      ovr_q     <= ovr_d;
      div_q     <= div_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
    end
  end

  // NOTE: FIFO storage is not reset; the count and pointers alone decide
  // which entries are valid, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (push_ok)
      mem_q[wr_ptr_q] <= Din[7:0];
  end

  always_comb begin
    Dout = '0;
    unique case (Addr[1:0])
      A_DATA:  Dout = '0;
      A_CTRL:  Dout = {30'd0, irqen_q, txen_q};
      A_STAT:  Dout = {23'd0, 5'(count_q), ovr_q, fifo_full, fifo_empty,
                       state_q != S_IDLE};
      default: Dout = {16'd0, div_q};
    endcase
  end

  assign txd = txd_q;
  assign IRQ = irqen_q && fifo_empty && (state_q == S_IDLE);

endmodule
